l2_request_arbiter: RTL and testbench

L2_REQUEST_ARBITER -- requirements
Module: l2_request_arbiter

---
 rtl/cache_pkg.sv | 15 +
 rtl/rr_priority_select.sv | 31 +++
 rtl/l2_request_arbiter.sv | 134 +++++++++++++
 tb/tb_l2_request_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and default geometry for the L2 request arbiter and its helpers.
package cache_pkg;

  localparam int DEF_ADDR_WIDTH    = 32;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_NUM_L1_CACHES = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    RESPOND   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set request bit at or above ptr_i, wrapping past N-1 to 0.
module rr_priority_select #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [N-1:0]         hit;
  logic [N-1:0][IW-1:0] cand;

  // cand[gi] is the requester sitting gi places after the pointer.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum      = {1'b0, ptr_i} + (IW+1)'(gi);
    assign cand[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    assign hit[gi]  = req_i[cand[gi]];
  end

  always_comb begin
    found_o = |hit;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) idx_o = cand[k];
    end
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter funnelling NUM_L1_CACHES L1 requesters onto one L2 command port,
// one outstanding transaction at a time, with a response timeout.
module l2_request_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int NUM_L1_CACHES = DEF_NUM_L1_CACHES,
  parameter int RESP_TIMEOUT  = 255
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_L1_CACHES-1:0]                 l1_req,
  input  logic [NUM_L1_CACHES-1:0]                 l1_write,
  input  logic [NUM_L1_CACHES-1:0][ADDR_WIDTH-1:0] l1_addr,
  input  logic [NUM_L1_CACHES-1:0][DATA_WIDTH-1:0] l1_wdata,
  output logic [NUM_L1_CACHES-1:0]                 l1_ready,
  output logic [DATA_WIDTH-1:0]                    l1_rdata,
  output logic                                     l2_valid,
  output logic                                     l2_write,
  output logic [ADDR_WIDTH-1:0]                    l2_addr,
  output logic [DATA_WIDTH-1:0]                    l2_wdata,
  input  logic                                     l2_accept,
  input  logic                                     l2_resp_valid,
  input  logic [DATA_WIDTH-1:0]                    l2_rdata,
  output logic [$clog2(NUM_L1_CACHES)-1:0]         grant_id,
  output logic                                     busy,
  output logic                                     timeout_err
);

  localparam int IW = $clog2(NUM_L1_CACHES);
  localparam int CW = (RESP_TIMEOUT < 1) ? 1 : $clog2(RESP_TIMEOUT + 1);

  arb_state_t               state_q;
  logic [IW-1:0]            rr_ptr_q;
  logic [IW-1:0]            rr_ptr_d;
  logic [IW-1:0]            grant_q;
  logic [NUM_L1_CACHES-1:0] ready_q;
  logic [NUM_L1_CACHES-1:0] grant_onehot;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     l2_valid_q;
  logic                     write_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     busy_q;
  logic                     tmo_err_q;
  logic [CW-1:0]            count_q;

  logic                     sel_found;
  logic [IW-1:0]            sel_idx;

  rr_priority_select #(
    .N (NUM_L1_CACHES)
  ) u_rr_select (
    .req_i   (l1_req),
    .ptr_i   (rr_ptr_q),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  assign grant_onehot = NUM_L1_CACHES'(1) << grant_q;
  assign rr_ptr_d     = (grant_q == IW'(NUM_L1_CACHES - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      ready_q    <= '0;
      rdata_q    <= '0;
      l2_valid_q <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      tmo_err_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      ready_q <= '0;
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            grant_q    <= sel_idx;
            write_q    <= l1_write[sel_idx];
            addr_q     <= l1_addr[sel_idx];
            wdata_q    <= l1_wdata[sel_idx];
            l2_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (l2_accept) begin
            l2_valid_q <= 1'b0;
            count_q    <= '0;
            state_q    <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // A strobe arriving on the timeout cycle still wins over the timeout.
          if (l2_resp_valid) begin
            rdata_q <= l2_rdata;
            ready_q <= grant_onehot;
            state_q <= RESPOND;
          end else if (count_q == CW'(RESP_TIMEOUT)) begin
            rdata_q   <= '1;
            tmo_err_q <= 1'b1;
            ready_q   <= grant_onehot;
            state_q   <= RESPOND;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        RESPOND: begin
          rr_ptr_q <= rr_ptr_d;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign l1_ready    = ready_q;
  assign l1_rdata    = rdata_q;
  assign l2_valid    = l2_valid_q;
  assign l2_write    = write_q;
  assign l2_addr     = addr_q;
  assign l2_wdata    = wdata_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed plus randomized transactions against a round-robin reference model of the arbiter.
module tb_l2_request_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 255;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         l1_req;
  logic [N-1:0]         l1_write;
  logic [N-1:0][AW-1:0] l1_addr;
  logic [N-1:0][DW-1:0] l1_wdata;
  logic [N-1:0]         l1_ready;
  logic [DW-1:0]        l1_rdata;
  logic                 l2_valid;
  logic                 l2_write;
  logic [AW-1:0]        l2_addr;
  logic [DW-1:0]        l2_wdata;
  logic                 l2_accept;
  logic                 l2_resp_valid;
  logic [DW-1:0]        l2_rdata;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int ptr_m    = 0;
  bit tmo_m    = 1'b0;
  int wait_rounds [N];

  l2_request_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .NUM_L1_CACHES (N),
    .RESP_TIMEOUT  (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .l1_req        (l1_req),
    .l1_write      (l1_write),
    .l1_addr       (l1_addr),
    .l1_wdata      (l1_wdata),
    .l1_ready      (l1_ready),
    .l1_rdata      (l1_rdata),
    .l2_valid      (l2_valid),
    .l2_write      (l2_write),
    .l2_addr       (l2_addr),
    .l2_wdata      (l2_wdata),
    .l2_accept     (l2_accept),
    .l2_resp_valid (l2_resp_valid),
    .l2_rdata      (l2_rdata),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first requester at or after ptr, counting modulo N.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    ptr_m = 0;
    tmo_m = 1'b0;
    for (int i = 0; i < N; i++) wait_rounds[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    model_reset();
  endtask

  // One full transaction starting from IDLE with l1_req already driven.
  // rsp_dly < 0 means the L2 never answers.
  task automatic txn(input int acc_dly, input int rsp_dly, input logic [31:0] rdat,
                     input bit drop_early, output int g_obs);
    int            g;
    int            edges;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic          ewr;
    logic [DW-1:0] exp_rd;
    g   = pick(l1_req, ptr_m);
    ea  = l1_addr[g];
    ew  = l1_wdata[g];
    ewr = l1_write[g];
    step();
    g_obs = int'(grant_id);
    chk("grant_id", 64'(grant_id), 64'(g));
    chk("busy_issue", 64'(busy), 64'(1));
    chk("l2_valid_issue", 64'(l2_valid), 64'(1));
    chk("l2_addr", 64'(l2_addr), 64'(ea));
    chk("l2_wdata", 64'(l2_wdata), 64'(ew));
    chk("l2_write", 64'(l2_write), 64'(ewr));
    for (int i = 0; i < N; i++) begin
      if (l1_req[i] && i != g_obs) wait_rounds[i]++;
    end
    chk("fair_rounds_ok", 64'(wait_rounds[g_obs] <= N), 64'(1));
    wait_rounds[g_obs] = 0;
    l1_addr[g]  = $urandom;
    l1_wdata[g] = $urandom;
    if (drop_early) l1_req[g] = 1'b0;
    for (int i = 0; i < acc_dly; i++) begin
      l2_accept     = 1'b0;
      l2_resp_valid = (i == 0);
      l2_rdata      = $urandom;
      step();
      chk("hold_valid", 64'(l2_valid), 64'(1));
      chk("hold_addr", 64'(l2_addr), 64'(ea));
      chk("hold_wdata", 64'(l2_wdata), 64'(ew));
    end
    l2_resp_valid = 1'b0;
    l2_accept     = 1'b1;
    step();
    l2_accept = 1'b0;
    chk("valid_after_accept", 64'(l2_valid), 64'(0));
    chk("ready_before_resp", 64'(l1_ready), 64'(0));
    edges = 0;
    if (rsp_dly >= 0) begin
      for (int i = 0; i < rsp_dly; i++) begin
        step();
        edges++;
        chk("ready_while_waiting", 64'(l1_ready), 64'(0));
      end
      l2_resp_valid = 1'b1;
      l2_rdata      = rdat;
      exp_rd        = rdat;
      step();
      l2_resp_valid = 1'b0;
      l2_rdata      = $urandom;
    end else begin
      exp_rd = '1;
      tmo_m  = 1'b1;
      while (l1_ready == '0 && edges < TMO + 40) begin
        step();
        edges++;
      end
      chk("timeout_latency", 64'(edges), 64'(TMO + 1));
    end
    chk("ready_onehot", 64'(l1_ready), 64'(4'b0001 << g));
    chk("l1_rdata", 64'(l1_rdata), 64'(exp_rd));
    chk("timeout_err", 64'(timeout_err), 64'(tmo_m));
    $display("txn: grant %0d acc_dly %0d rsp_dly %0d rdata 0x%08h", g_obs, acc_dly, rsp_dly, l1_rdata);
    l1_req[g] = 1'b0;
    ptr_m     = (g + 1) % N;
    step();
    chk("ready_single_pulse", 64'(l1_ready), 64'(0));
    chk("busy_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    int g;
    int prev_g;
    reset         = 1'b0;
    l1_req        = '0;
    l1_write      = '0;
    l1_addr       = '0;
    l1_wdata      = '0;
    l2_accept     = 1'b0;
    l2_resp_valid = 1'b0;
    l2_rdata      = '0;
    model_reset();
    step();
    step();
    chk("rst_ready", 64'(l1_ready), 64'(0));
    chk("rst_rdata", 64'(l1_rdata), 64'(0));
    chk("rst_l2_valid", 64'(l2_valid), 64'(0));
    chk("rst_l2_addr", 64'(l2_addr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant", 64'(grant_id), 64'(0));
    chk("rst_timeout_err", 64'(timeout_err), 64'(0));
    reset = 1'b1;

    // Single read, minimum latency.
    l1_req     = 4'b0001;
    l1_write   = 4'b0000;
    l1_addr[0] = 32'h0000_0004;
    txn(0, 0, 32'hCAFE_0001, 1'b0, g);

    // All four request together straight after reset.
    do_reset();
    for (int i = 0; i < N; i++) begin
      l1_write[i] = 1'($urandom);
      l1_addr[i]  = $urandom;
      l1_wdata[i] = $urandom;
    end
    l1_req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      txn(0, i, $urandom, 1'b0, g);
      chk("order_all", 64'(g), 64'(i));
    end

    // Write under five cycles of backpressure.
    l1_req      = 4'b0010;
    l1_write[1] = 1'b1;
    l1_addr[1]  = 32'h0000_0008;
    l1_wdata[1] = 32'h1234_5678;
    txn(5, 1, 32'h0BAD_F00D, 1'b0, g);

    // Silent L2: timeout, then flag stays sticky on a normal transaction.
    l1_req = 4'b0001;
    txn(0, -1, 32'h0, 1'b0, g);
    l1_req = 4'b0100;
    txn(1, 2, 32'h5555_AAAA, 1'b0, g);

    // req[3] held while req[0] re-requests after each service.
    prev_g = -1;
    for (int t = 0; t < 6; t++) begin
      l1_req[3] = 1'b1;
      l1_req[0] = 1'b1;
      txn(0, 0, $urandom, 1'b0, g);
      if (t > 0) chk("alternate_0_3", 64'(g != prev_g), 64'(1));
      prev_g = g;
    end
    l1_req = '0;

    // Requester withdraws right after being latched.
    l1_req = 4'b0100;
    txn(1, 1, 32'h7777_0001, 1'b1, g);

    // Randomized traffic; requests stay up until served.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!l1_req[i] && $urandom_range(0, 1) == 1) begin
          l1_req[i]   = 1'b1;
          l1_write[i] = 1'($urandom);
          l1_addr[i]  = $urandom;
          l1_wdata[i] = $urandom;
        end
      end
      if (l1_req == '0) l1_req[$urandom_range(0, N - 1)] = 1'b1;
      txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom_range(0, 7) == 0, g);
    end

    // Reset while waiting for the L2 response with req[2] pending.
    l1_req      = 4'b0100;
    l1_addr[2]  = 32'h0000_0020;
    l1_wdata[2] = 32'hDEAD_0002;
    step();
    chk("pre_rst_valid", 64'(l2_valid), 64'(1));
    l2_accept = 1'b1;
    step();
    l2_accept = 1'b0;
    step();
    #3;
    reset = 1'b0;
    #1;
    chk("async_ready", 64'(l1_ready), 64'(0));
    chk("async_rdata", 64'(l1_rdata), 64'(0));
    chk("async_l2_valid", 64'(l2_valid), 64'(0));
    chk("async_l2_write", 64'(l2_write), 64'(0));
    chk("async_l2_addr", 64'(l2_addr), 64'(0));
    chk("async_l2_wdata", 64'(l2_wdata), 64'(0));
    chk("async_busy", 64'(busy), 64'(0));
    chk("async_grant", 64'(grant_id), 64'(0));
    chk("async_timeout_err", 64'(timeout_err), 64'(0));
    step();
    reset = 1'b1;
    model_reset();
    txn(0, 0, 32'h2222_2222, 1'b0, g);
    chk("regrant_after_reset", 64'(g), 64'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
